// File: rtl/fb_pkg.sv
// Frame-buffer types shared by the port arbiter and its write queue.
// QVGA RGB565, one 16-bit word per pixel.
package fb_pkg;

    localparam int unsigned FB_W     = 320;
    localparam int unsigned FB_H     = 240;
    localparam int unsigned FB_WORDS = FB_W * FB_H;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned PIX_W    = 16;

    typedef logic [PIX_W-1:0]  rgb565_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] data;
    } fb_wr_t;

    // True when a word address falls inside a frame buffer of 'words' entries.
    function automatic logic addr_in_range(input fb_addr_t addr, input int unsigned words);
        return 32'(addr) < words;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO for queued camera writes; no pass-through when full.
// Contents are discarded on reset.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  fb_wr_t                     din,
    input  logic                       pop,
    output fb_wr_t                     dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    fb_wr_t             store [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign dout    = store[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Payload storage needs no reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads have absolute priority,
// camera writes are queued and drained in blanking or pixel-repeat slots.
module fb_port_arbiter
    import fb_pkg::ADDR_W, fb_pkg::PIX_W, fb_pkg::fb_wr_t, fb_pkg::fb_addr_t,
           fb_pkg::rgb565_t, fb_pkg::addr_in_range;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FB_WORDS   = fb_pkg::FB_WORDS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vga_den,
    input  logic [ADDR_W-1:0]             vga_addr,
    output logic [PIX_W-1:0]              vga_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [PIX_W-1:0]              wr_data,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [PIX_W-1:0]              mem_wdata,
    input  logic [PIX_W-1:0]              mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          addr_err
);

    logic       run_q;
    fb_addr_t   last_addr_q;
    logic       last_valid_q;
    logic       rd_q;
    logic       rd_oor_q;
    rgb565_t    hold_q;
    logic       addr_err_q;

    fb_wr_t     fifo_head;
    fb_wr_t     fifo_din;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push_c;

    logic       same_c;
    logic       rd_slot_c;
    logic       rd_ok_c;
    logic       wr_slot_c;
    logic       wr_ok_c;
    logic       hazard_c;

    assign fifo_din = '{addr: wr_addr, data: wr_data};
    assign wr_ready = run_q && !fifo_full;
    assign push_c   = wr_valid && wr_ready;
    assign addr_err = addr_err_q;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_c),
        .din     (fifo_din),
        .pop     (wr_slot_c),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Slot decision: new read address wins, otherwise the queue head may use the port.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        same_c    = last_valid_q && (vga_addr == last_addr_q);
        rd_slot_c = run_q && vga_den && !same_c;
        rd_ok_c   = addr_in_range(vga_addr, FB_WORDS);
        wr_slot_c = run_q && !rd_slot_c && !fifo_empty;
        wr_ok_c   = addr_in_range(fifo_head.addr, FB_WORDS);
        hazard_c  = wr_slot_c && last_valid_q && (fifo_head.addr == last_addr_q);

        if (rd_slot_c) begin
            if (rd_ok_c) begin
                mem_en   = 1'b1;
                mem_addr = vga_addr;
            end
        end else if (wr_slot_c && wr_ok_c) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = fifo_head.addr;
            mem_wdata = fifo_head.data;
        end
    end

    // Fresh read data passes straight through; repeated pixels come from the hold register.
    always_comb begin
        vga_data = hold_q;
        if (rd_q) begin
            vga_data = rd_oor_q ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q        <= 1'b0;
            last_addr_q  <= '0;
            last_valid_q <= 1'b0;
            rd_q         <= 1'b0;
            rd_oor_q     <= 1'b0;
            hold_q       <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            rd_q     <= rd_slot_c;
            rd_oor_q <= rd_slot_c && !rd_ok_c;

            if (!vga_den) begin
                last_valid_q <= 1'b0;
            end else if (rd_slot_c) begin
                last_valid_q <= rd_ok_c;
                if (rd_ok_c) begin
                    last_addr_q <= vga_addr;
                end
            end
            // A write to the cached address invalidates it so the next request re-reads.
            if (hazard_c) begin
                last_valid_q <= 1'b0;
            end

            if (rd_q) begin
                hold_q <= rd_oor_q ? '0 : mem_rdata;
            end

            if ((rd_slot_c && !rd_ok_c) || (wr_slot_c && !wr_ok_c)) begin
                addr_err_q <= 1'b1;
            end
        end
    end

endmodule
